// File: rtl/seven_segment_pkg.sv
// Shared types and the hex glyph table for the multiplexed
// seven-segment scanner.
package seven_segment_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scanState_t;

    // Index n holds the glyph for nibble n; bit 6 is segment A, bit 0 is G.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,
        7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33,
        7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] hexEncode(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Nibble to logical (active-high) seven-segment glyph.
// Polarity is applied by the scanner, not here.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = hexEncode(nibble);
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment scanner with guard gaps,
// frame-synchronous data commit and leading-zero blanking.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 25000,
    parameter int GUARD_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int IDX_W =
        (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX =
        (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W =
        (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GUARD_LAST =
        CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST =
        CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST =
        IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_INV =
        (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_INV =
        (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    scanState_t state;
    scanState_t stateNext;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idxNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic primed;
    logic frameEdge;

    logic [4*NUM_DIGITS-1:0] pendVal;
    logic [NUM_DIGITS-1:0]   pendDp;
    logic                    pendLz;
    logic [4*NUM_DIGITS-1:0] actVal;
    logic [NUM_DIGITS-1:0]   actDp;
    logic                    actLz;
    logic [4*NUM_DIGITS-1:0] actValNext;
    logic [NUM_DIGITS-1:0]   actDpNext;
    logic                    actLzNext;

    logic [3:0]            nibble;
    logic                  dpBit;
    logic                  zeroRun;
    logic [NUM_DIGITS-1:0] slotHot;
    logic [NUM_DIGITS-1:0] blankMask;
    logic                  showDigit;
    logic [6:0]            segCode;
    logic [6:0]            segNext;
    logic                  dpNext;
    logic [NUM_DIGITS-1:0] digNext;

    // The first edge out of reset is treated as a frame boundary so
    // that frame_start fires immediately and the guard runs in full.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        cntNext   = cnt + CNT_W'(1);
        frameEdge = 1'b0;
        if (!primed) begin
            stateNext = GUARD;
            idxNext   = '0;
            cntNext   = '0;
            frameEdge = 1'b1;
        end else begin
            unique case (state)
                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        stateNext = DRIVE;
                        cntNext   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        stateNext = GUARD;
                        cntNext   = '0;
                        if (idx == IDX_LAST) begin
                            idxNext   = '0;
                            frameEdge = 1'b1;
                        end else begin
                            idxNext = idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        actValNext = actVal;
        actDpNext  = actDp;
        actLzNext  = actLz;
        if (frameEdge) begin
            if (load) begin
                actValNext = value;
                actDpNext  = dp;
                actLzNext  = lz_blank;
            end else begin
                actValNext = pendVal;
                actDpNext  = pendDp;
                actLzNext  = pendLz;
            end
        end
    end

    // Scan from the top digit down; a digit is blanked while every
    // nibble at or above it is zero. Digit 0 is always shown.
    always_comb begin
        nibble    = '0;
        dpBit     = 1'b0;
        zeroRun   = 1'b1;
        slotHot   = '0;
        blankMask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroRun = zeroRun && (actValNext[4*i +: 4] == 4'h0);
            blankMask[i] = actLzNext && zeroRun && (i > 0);
            if (idxNext == IDX_W'(i)) begin
                nibble     = actValNext[4*i +: 4];
                dpBit      = actDpNext[i];
                slotHot[i] = 1'b1;
            end
        end
    end

    seven_segment_decoder u_decoder (
        .nibble   (nibble),
        .segments (segCode)
    );

    always_comb begin
        showDigit = (stateNext == DRIVE) &&
                    ((blankMask & slotHot) == '0);
        segNext = (showDigit ? segCode : 7'h00) ^ SEG_INV;
        dpNext  = (showDigit && dpBit) ^ DP_INV;
        digNext = (showDigit ? slotHot : '0) ^ DIG_INV;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= GUARD;
            idx    <= '0;
            cnt    <= '0;
            primed <= 1'b0;
        end else begin
            state  <= stateNext;
            idx    <= idxNext;
            cnt    <= cntNext;
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendVal <= '0;
            pendDp  <= '0;
            pendLz  <= 1'b0;
            actVal  <= '0;
            actDp   <= '0;
            actLz   <= 1'b0;
        end else begin
            if (load) begin
                pendVal <= value;
                pendDp  <= dp;
                pendLz  <= lz_blank;
            end
            actVal <= actValNext;
            actDp  <= actDpNext;
            actLz  <= actLzNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_INV;
            seg_dp      <= DP_INV;
            digit_en    <= DIG_INV;
            frame_start <= 1'b0;
        end else begin
            seg         <= segNext;
            seg_dp      <= dpNext;
            digit_en    <= digNext;
            frame_start <= frameEdge;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed frame-by-frame check of the seven-segment scanner
// with four digits, 4-cycle slots and 2-cycle guards.
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_blank;
    logic        load;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  digit_en;
    logic        frame_start;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .GUARD_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp          (dp),
        .lz_blank    (lz_blank),
        .load        (load),
        .seg         (seg),
        .seg_dp      (seg_dp),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    task automatic checkEq(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus order: {frame_start, digit_en, seg_dp, seg}
    task automatic expectFrame(
        input int              fr,
        input logic [3:0][6:0] segs,
        input logic [3:0]      dps,
        input logic [3:0]      en,
        input int              stopAt,
        input int              ldAt,
        input int              ldN,
        input logic [15:0]     vA,
        input logic [15:0]     vB,
        input logic [3:0]      ldDp,
        input logic            ldLz
    );
        for (int c = 0; c < stopAt; c++) begin
            int          slot;
            int          ph;
            logic        on;
            logic [12:0] exp;
            slot = c / 6;
            ph   = c % 6;
            on   = (ph >= 2) && en[slot];
            exp  = {(c == 0) ? 1'b1 : 1'b0,
                    on ? ~(4'b0001 << slot) : 4'hF,
                    on ? ~dps[slot] : 1'b1,
                    on ? ~segs[slot] : 7'h7F};
            checkEq($sformatf("frame%0d_cycle%0d", fr, c),
                    {19'd0, frame_start, digit_en, seg_dp, seg},
                    {19'd0, exp});
            if (ldAt >= 0 && c >= ldAt && c < ldAt + ldN) begin
                value    = (c == ldAt) ? vA : vB;
                dp       = ldDp;
                lz_blank = ldLz;
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        lz_blank = 1'b0;
        #1;
        checkEq("reset_async",
                {19'd0, frame_start, digit_en, seg_dp, seg},
                {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
        step();
        step();
        checkEq("reset_hold",
                {19'd0, frame_start, digit_en, seg_dp, seg},
                {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
        rst = 1'b0;
        step();

        // Post-reset 0000, mid-frame load of 12AF
        expectFrame(1, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000,
                    4'b1111, 24, 5, 1, 16'h12AF, 16'h0000,
                    4'b0100, 1'b0);
        // 12AF shown F,A,2.,1; load 0005 with blanking
        expectFrame(2, {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0100,
                    4'b1111, 24, 7, 1, 16'h0005, 16'h0000,
                    4'b1111, 1'b1);
        // Only slot 0 lit; dp of blanked digits ignored
        expectFrame(3, {7'h00, 7'h00, 7'h00, 7'h5B}, 4'b0001,
                    4'b0001, 24, 3, 1, 16'h0305, 16'h0000,
                    4'b0000, 1'b1);
        // 0305: top digit blanked, inner zero kept
        expectFrame(4, {7'h00, 7'h79, 7'h7E, 7'h5B}, 4'b0000,
                    4'b0111, 24, 8, 2, 16'h1111, 16'h2222,
                    4'b0000, 1'b0);
        // Back-to-back loads: only 2222; load BEEF on wrap edge
        expectFrame(5, {7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b0000,
                    4'b1111, 24, 23, 1, 16'hBEEF, 16'h0000,
                    4'b1000, 1'b0);
        // BEEF shown F,E,E,b.; pending 9999 then reset in slot 2
        expectFrame(6, {7'h1F, 7'h4F, 7'h4F, 7'h47}, 4'b1000,
                    4'b1111, 15, 5, 1, 16'h9999, 16'h0000,
                    4'b1111, 1'b1);

        checkEq("pre_reset_drive2",
                {28'd0, digit_en}, {28'd0, 4'b1011});
        #2;
        rst = 1'b1;
        #1;
        checkEq("reset_mid_drive",
                {19'd0, frame_start, digit_en, seg_dp, seg},
                {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
        step();
        checkEq("reset_mid_hold",
                {19'd0, frame_start, digit_en, seg_dp, seg},
                {19'd0, 1'b0, 4'hF, 1'b1, 7'h7F});
        rst = 1'b0;
        step();

        // Pending 9999 discarded: 0000, then next frame_start
        expectFrame(7, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000,
                    4'b1111, 24, -1, 0, 16'h0000, 16'h0000,
                    4'b0000, 1'b0);
        expectFrame(8, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000,
                    4'b1111, 1, -1, 0, 16'h0000, 16'h0000,
                    4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning digit count (legal range 1..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 25000, meaning clk cycles per digit drive slot (>=1).
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 16, meaning all-off cycles before each slot (>=1).
REQ-004 The block SHALL have parameters SEG_ACTIVE_LOW and DIG_ACTIVE_LOW, default 1 each, meaning output polarity.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles; digit i = value[4i+3:4i].
REQ-008 The block SHALL have port dp, input, NUM_DIGITS bits: decimal point per digit.
REQ-009 The block SHALL have port lz_blank, input, 1 bit: leading-zero suppression enable.
REQ-010 The block SHALL have port load, input, 1 bit: capture value/dp/lz_blank into the pending register.
REQ-011 The block SHALL have port seg, output, 7 bits: seg[6]..seg[0] = segments A..G.
REQ-012 The block SHALL have port seg_dp, output, 1 bit: decimal point segment.
REQ-013 The block SHALL have port digit_en, output, NUM_DIGITS bits: digit common enables.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at frame start.

Function
REQ-015 The FSM SHALL have states GUARD and DRIVE, with digit index idx and cycle counter cnt.
- GUARD: all digit_en and segments inactive; runs GUARD_CYCLES cycles, then goes to DRIVE with idx unchanged.
- DRIVE: runs SCAN_DIV cycles, then goes to GUARD with idx+1, wrapping N-1 -> 0.
REQ-016 All outputs SHALL be registered, taking the value of the state entered on the same edge.
REQ-017 In DRIVE, digit_en[idx] SHALL be active and all other digits inactive.
REQ-018 seg SHALL be the hex encoding of the active nibble: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47, before polarity.
REQ-019 seg_dp SHALL be driven from active dp[idx].
REQ-020 Polarity: active-low level SHALL equal the inverse of the logical value when *_ACTIVE_LOW=1.
REQ-021 A load at an edge SHALL overwrite pending; back-to-back loads SHALL leave only the last one.
REQ-022 Pending SHALL commit to the active register on the DRIVE->GUARD edge where idx wraps N-1 -> 0; load on that same edge SHALL commit the new data directly.
REQ-023 Displayed data SHALL never change mid-frame.
REQ-024 frame_start SHALL pulse on the edge entering GUARD with idx=0.
REQ-025 Frame length SHALL be NUM_DIGITS*(GUARD_CYCLES+SCAN_DIV) cycles.
REQ-026 With active lz_blank=1, digit i>0 SHALL be blanked when nibbles i..N-1 are all zero; digit 0 is never blanked.
REQ-027 For a blanked digit, digit_en SHALL stay inactive for the whole slot, timing SHALL be unchanged, and dp SHALL be ignored.

Reset
REQ-028 On rst assertion, with no clock needed, state SHALL be GUARD, idx=0, cnt=0, and pending/active registers SHALL be all zero (including lz_blank).
REQ-029 Under reset, all seg, seg_dp and digit_en SHALL be at their inactive level and frame_start SHALL be 0.
REQ-030 Reset mid-frame SHALL discard any uncommitted pending load.
REQ-031 After deassertion, the first frame SHALL begin with GUARD and idx=0, and frame_start SHALL pulse on the first edge after deassertion.

Structure
REQ-032 Package seven_segment_pkg SHALL hold the FSM state enum and the 16-entry hex encoding constant table.
REQ-033 Sub-module seven_segment_decoder SHALL provide a combinational nibble -> 7-bit logical encoding; the top instantiates it once, on the active nibble.

Verification
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=2, both polarities active-low.
REQ-034 Load value=16'h12AF, dp=4'b0100 mid-frame -> the next frame drives, in order:
- digit_en=1110 with seg=~7'h47
- digit_en=1101 with seg=~7'h77
- digit_en=1011 with seg=~7'h6D and seg_dp=0
- digit_en=0111 with seg=~7'h30
Each digit is held 4 cycles with 2 all-off cycles between; the frame is 24 cycles and frame_start recurs every 24 cycles.
REQ-035 Load 16'h0005 with lz_blank=1 -> digit_en active only in slot 0 (seg=~7'h5B); slots 1-3 stay all-off but keep 6-cycle timing.
REQ-036 Load 16'h1111, then 16'h2222 one cycle later, both before the wrap -> the next frame shows only 2; no frame shows a mix.
REQ-037 Assert rst during a DRIVE of digit 2 with a pending load -> all outputs inactive asynchronously; after release the display is 0000 and frame_start pulses.
REQ-038 Load asserted exactly on the wrap edge with 16'hBEEF -> the immediately following frame shows F,E,E,b.
